// File: rtl/riscv_amo_pkg.sv
// Shared AMO opcode encodings and sequencer state type for the RV64A AMO controller.
package riscv_amo_pkg;

   localparam logic [4:0] AMO_ADD  = 5'b00000;
   localparam logic [4:0] AMO_SWAP = 5'b00001;
   localparam logic [4:0] AMO_XOR  = 5'b00100;
   localparam logic [4:0] AMO_OR   = 5'b01000;
   localparam logic [4:0] AMO_AND  = 5'b01100;
   localparam logic [4:0] AMO_MIN  = 5'b10000;
   localparam logic [4:0] AMO_MAX  = 5'b10100;
   localparam logic [4:0] AMO_MINU = 5'b11000;
   localparam logic [4:0] AMO_MAXU = 5'b11100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_CALC,
      ST_WRITE,
      ST_DONE
   } amo_state_e;

endpackage

// File: rtl/riscv_amo_alu.sv
// Combinational AMO arithmetic: result = f(old, rs2) for .W and .D operations.
module riscv_amo_alu
   import riscv_amo_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] old_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      funct5_i,
   input  logic            word_i,
   output logic [XLEN-1:0] result_o
);

   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [XLEN-1:0] r;
   logic            lt_s;
   logic            lt_u;

   // .W operands are sign-extended to full width; this keeps both signed and
   // unsigned ordering of the low 32 bits, so one comparator serves both sizes.
   always_comb begin
      a = word_i ? {{(XLEN-32){old_i[31]}}, old_i[31:0]} : old_i;
      b = word_i ? {{(XLEN-32){rs2_i[31]}}, rs2_i[31:0]} : rs2_i;
      lt_s = $signed(a) < $signed(b);
      lt_u = a < b;
      case (funct5_i)
         AMO_SWAP: r = b;
         AMO_ADD:  r = a + b;
         AMO_XOR:  r = a ^ b;
         AMO_AND:  r = a & b;
         AMO_OR:   r = a | b;
         AMO_MIN:  r = lt_s ? a : b;
         AMO_MAX:  r = lt_s ? b : a;
         AMO_MINU: r = lt_u ? a : b;
         AMO_MAXU: r = lt_u ? b : a;
         default:  r = a;
      endcase
      result_o = word_i ? {{(XLEN-32){r[31]}}, r[31:0]} : r;
   end

endmodule

// File: rtl/riscv_amo_ctrl.sv
// RV64A AMO sequencer: read-modify-write on the dcache port, stalls the pipe while busy.
module riscv_amo_ctrl
   import riscv_amo_pkg::*;
#(
   parameter int XLEN               = 64,
   parameter int AMO_ADDR_ALIGN_CHK = 1
) (
   input  logic            i_riscv_lsu_clk,
   input  logic            i_riscv_lsu_rst,
   input  logic            i_riscv_amo_start,
   input  logic [4:0]      i_riscv_amo_funct5,
   input  logic            i_riscv_amo_word,
   input  logic [XLEN-1:0] i_riscv_amo_addr,
   input  logic [XLEN-1:0] i_riscv_amo_rs2,
   input  logic            i_riscv_amo_goto_trap,
   input  logic [1:0]      i_riscv_amo_return_trap,
   input  logic            i_riscv_amo_dcache_stall,
   input  logic [XLEN-1:0] i_riscv_amo_dcache_rdata,
   output logic            o_riscv_amo_dcache_rden,
   output logic            o_riscv_amo_dcache_wren,
   output logic [XLEN-1:0] o_riscv_amo_dcache_addr,
   output logic [XLEN-1:0] o_riscv_amo_dcache_wdata,
   output logic            o_riscv_amo_dcache_word,
   output logic            o_riscv_amo_busy,
   output logic            o_riscv_amo_done,
   output logic [XLEN-1:0] o_riscv_amo_rd_value,
   output logic            o_riscv_amo_clr_reserv,
   output logic            o_riscv_amo_misaligned
);

   amo_state_e      state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] rs2_q, rs2_d;
   logic [4:0]      op_q, op_d;
   logic            word_q, word_d;
   logic [XLEN-1:0] old_q, old_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [XLEN-1:0] alu_res;
   logic            misal;
   logic            req_ok;

   riscv_amo_alu #(.XLEN(XLEN)) u_alu (
      .old_i    (old_q),
      .rs2_i    (rs2_q),
      .funct5_i (op_q),
      .word_i   (word_q),
      .result_o (alu_res)
   );

   always_ff @(posedge i_riscv_lsu_clk or posedge i_riscv_lsu_rst) begin
      if (i_riscv_lsu_rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         rs2_q    <= '0;
         op_q     <= '0;
         word_q   <= 1'b0;
         old_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rs2_q    <= rs2_d;
         op_q     <= op_d;
         word_q   <= word_d;
         old_q    <= old_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rs2_d    = rs2_q;
      op_d     = op_q;
      word_d   = word_q;
      old_d    = old_q;
      result_d = result_q;

      o_riscv_amo_dcache_rden  = 1'b0;
      o_riscv_amo_dcache_wren  = 1'b0;
      o_riscv_amo_dcache_addr  = '0;
      o_riscv_amo_dcache_wdata = '0;
      o_riscv_amo_dcache_word  = 1'b0;
      o_riscv_amo_busy         = 1'b0;
      o_riscv_amo_done         = 1'b0;
      o_riscv_amo_clr_reserv   = 1'b0;
      o_riscv_amo_misaligned   = 1'b0;

      misal  = i_riscv_amo_word ? (|i_riscv_amo_addr[1:0]) : (|i_riscv_amo_addr[2:0]);
      req_ok = i_riscv_amo_start && !i_riscv_amo_goto_trap && (i_riscv_amo_return_trap == 2'b00);

      case (state_q)
         ST_IDLE: begin
            if (req_ok) begin
               if (!misal || (AMO_ADDR_ALIGN_CHK == 0)) begin
                  o_riscv_amo_busy = 1'b1;
                  addr_d  = i_riscv_amo_addr;
                  rs2_d   = i_riscv_amo_rs2;
                  op_d    = i_riscv_amo_funct5;
                  word_d  = i_riscv_amo_word;
                  state_d = ST_READ;
               end else begin
                  o_riscv_amo_misaligned = 1'b1;
               end
            end
         end
         ST_READ: begin
            o_riscv_amo_busy        = 1'b1;
            o_riscv_amo_dcache_rden = 1'b1;
            o_riscv_amo_dcache_addr = addr_q;
            o_riscv_amo_dcache_word = word_q;
            if (i_riscv_amo_goto_trap) begin
               state_d = ST_IDLE;
            end else if (!i_riscv_amo_dcache_stall) begin
               old_d   = word_q ? {{(XLEN-32){i_riscv_amo_dcache_rdata[31]}},
                                   i_riscv_amo_dcache_rdata[31:0]}
                                : i_riscv_amo_dcache_rdata;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            o_riscv_amo_busy = 1'b1;
            result_d = alu_res;
            state_d  = ST_WRITE;
         end
         ST_WRITE: begin
            o_riscv_amo_busy         = 1'b1;
            o_riscv_amo_dcache_wren  = 1'b1;
            o_riscv_amo_dcache_addr  = addr_q;
            o_riscv_amo_dcache_wdata = result_q;
            o_riscv_amo_dcache_word  = word_q;
            if (!i_riscv_amo_dcache_stall) begin
               o_riscv_amo_clr_reserv = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            o_riscv_amo_done = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign o_riscv_amo_rd_value = old_q;

endmodule

// File: tb/tb_riscv_amo_ctrl.sv
// Directed self-checking bench for riscv_amo_ctrl with hand-computed expectations.
module tb_riscv_amo_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic [4:0]  f5;
   logic        word;
   logic [63:0] addr;
   logic [63:0] rs2;
   logic        goto_trap;
   logic [1:0]  ret_trap;
   logic        stall;
   logic [63:0] rdata;
   logic        rden, wren, dword, busy, done, clr, misal;
   logic [63:0] daddr, wdata, rd;

   int checks = 0;
   int errors = 0;

   riscv_amo_ctrl #(.XLEN(64), .AMO_ADDR_ALIGN_CHK(1)) dut (
      .i_riscv_lsu_clk          (clk),
      .i_riscv_lsu_rst          (rst),
      .i_riscv_amo_start        (start),
      .i_riscv_amo_funct5       (f5),
      .i_riscv_amo_word         (word),
      .i_riscv_amo_addr         (addr),
      .i_riscv_amo_rs2          (rs2),
      .i_riscv_amo_goto_trap    (goto_trap),
      .i_riscv_amo_return_trap  (ret_trap),
      .i_riscv_amo_dcache_stall (stall),
      .i_riscv_amo_dcache_rdata (rdata),
      .o_riscv_amo_dcache_rden  (rden),
      .o_riscv_amo_dcache_wren  (wren),
      .o_riscv_amo_dcache_addr  (daddr),
      .o_riscv_amo_dcache_wdata (wdata),
      .o_riscv_amo_dcache_word  (dword),
      .o_riscv_amo_busy         (busy),
      .o_riscv_amo_done         (done),
      .o_riscv_amo_rd_value     (rd),
      .o_riscv_amo_clr_reserv   (clr),
      .o_riscv_amo_misaligned   (misal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_rden"}, {63'd0, rden}, 64'd0);
      chk({tag, "_wren"}, {63'd0, wren}, 64'd0);
      chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
      chk({tag, "_done"}, {63'd0, done}, 64'd0);
      chk({tag, "_clr"},  {63'd0, clr},  64'd0);
      chk({tag, "_addr"}, daddr, 64'd0);
   endtask

   // Stall-free AMO: accept at cycle 0, READ 1, CALC 2, WRITE 3, DONE 4.
   task automatic amo_run(input string tag, input logic [4:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] s2, input logic [63:0] mem,
                          input logic [63:0] exp_wdata, input logic [63:0] exp_rd);
      logic [63:0] m;
      m = w ? 64'h0000_0000_FFFF_FFFF : '1;
      start = 1'b1; f5 = op; word = w; addr = a; rs2 = s2; rdata = mem;
      #1;
      chk({tag, "_c0_busy"}, {63'd0, busy}, 64'd1);
      chk({tag, "_c0_rden"}, {63'd0, rden}, 64'd0);
      tick(); start = 1'b0; #1;
      chk({tag, "_c1_rden"}, {63'd0, rden}, 64'd1);
      chk({tag, "_c1_addr"}, daddr, a);
      chk({tag, "_c1_word"}, {63'd0, dword}, {63'd0, w});
      tick(); #1;
      chk({tag, "_c2_en"}, {62'd0, rden, wren}, 64'd0);
      chk({tag, "_c2_busy"}, {63'd0, busy}, 64'd1);
      tick(); #1;
      chk({tag, "_c3_wren"}, {62'd0, rden, wren}, 64'd1);
      chk({tag, "_c3_wdata"}, wdata & m, exp_wdata & m);
      chk({tag, "_c3_clr"}, {63'd0, clr}, 64'd1);
      tick(); #1;
      chk({tag, "_c4_done"}, {63'd0, done}, 64'd1);
      chk({tag, "_c4_busy"}, {63'd0, busy}, 64'd0);
      chk({tag, "_c4_rd"}, rd, exp_rd);
      chk({tag, "_c4_clr"}, {63'd0, clr}, 64'd0);
      tick(); #1;
      chk({tag, "_c5_done"}, {63'd0, done}, 64'd0);
      chk({tag, "_c5_rdhold"}, rd, exp_rd);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; f5 = '0; word = 1'b0; addr = '0; rs2 = '0;
      goto_trap = 1'b0; ret_trap = '0; stall = 1'b0; rdata = '0;
      #12;
      chk_quiet("reset");
      chk("reset_rd", rd, 64'd0);
      @(negedge clk); rst = 1'b0;
      tick();

      amo_run("add_d",   5'b00000, 1'b0, 64'h80,  64'd7, 64'd5, 64'd12, 64'd5);
      amo_run("max_w",   5'b10100, 1'b1, 64'h100, 64'd1, 64'h0000_0000_FFFF_FFFF,
              64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
      amo_run("maxu_w",  5'b11100, 1'b1, 64'h100, 64'd1, 64'h0000_0000_FFFF_FFFF,
              64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      amo_run("min_d",   5'b10000, 1'b0, 64'h8,   64'd2, 64'hFFFF_FFFF_FFFF_FFFD,
              64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD);
      amo_run("minu_d",  5'b11000, 1'b0, 64'h8,   64'd2, 64'hFFFF_FFFF_FFFF_FFFD,
              64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
      amo_run("add_w_wrap", 5'b00000, 1'b1, 64'h4, 64'd1, 64'h0000_0000_7FFF_FFFF,
              64'h0000_0000_8000_0000, 64'h0000_0000_7FFF_FFFF);
      amo_run("swap_w",  5'b00001, 1'b1, 64'h84,  64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_0011,
              64'h0000_0000_9ABC_DEF0, 64'd17);
      amo_run("xor_d",   5'b00100, 1'b0, 64'h10,  64'h0F0F, 64'h00FF, 64'h0FF0, 64'h00FF);
      amo_run("undef",   5'b00010, 1'b0, 64'h18,  64'd99, 64'h1234, 64'h1234, 64'h1234);

      // Stalls: 3 cycles in READ, 2 in WRITE -> DONE at cycle 9.
      start = 1'b1; f5 = 5'b00000; word = 1'b0; addr = 64'h40; rs2 = 64'd3; rdata = 64'd10;
      stall = 1'b1;
      tick(); start = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         #1;
         chk("stall_rd_rden", {62'd0, rden, wren}, 64'd2);
         chk("stall_rd_busy", {63'd0, busy}, 64'd1);
         tick();
      end
      stall = 1'b0; #1;
      chk("stall_rd_release", {62'd0, rden, wren}, 64'd2);
      tick(); tick(); stall = 1'b1;
      for (int c = 6; c <= 7; c++) begin
         #1;
         chk("stall_wr_wren", {62'd0, rden, wren}, 64'd1);
         chk("stall_wr_clr", {63'd0, clr}, 64'd0);
         chk("stall_wr_wdata", wdata, 64'd13);
         tick();
      end
      stall = 1'b0; #1;
      chk("stall_wr_release_clr", {63'd0, clr}, 64'd1);
      tick(); #1;
      chk("stall_c9_done", {63'd0, done}, 64'd1);
      chk("stall_c9_rd", rd, 64'd10);
      tick();

      // Trap while reading aborts without a store.
      start = 1'b1; f5 = 5'b00000; word = 1'b0; addr = 64'h20; rs2 = 64'd1; rdata = 64'd77;
      tick(); start = 1'b0; goto_trap = 1'b1; #1;
      chk("trap_rden", {63'd0, rden}, 64'd1);
      tick(); goto_trap = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk_quiet("trap_after");
         tick();
      end

      // Misaligned .D address: pulse only, no dcache traffic.
      start = 1'b1; f5 = 5'b00001; word = 1'b0; addr = 64'h84; rs2 = 64'd5; #1;
      chk("misal_pulse", {63'd0, misal}, 64'd1);
      chk_quiet("misal_c0");
      tick(); start = 1'b0; #1;
      chk("misal_clear", {63'd0, misal}, 64'd0);
      chk_quiet("misal_c1");
      tick();

      // Async reset in WRITE clears outputs immediately.
      start = 1'b1; f5 = 5'b00000; word = 1'b0; addr = 64'h60; rs2 = 64'd1; rdata = 64'd2;
      tick(); start = 1'b0; tick(); tick(); #1;
      chk("rstw_in_write", {63'd0, wren}, 64'd1);
      rst = 1'b1; #1;
      chk_quiet("rstw_async");
      chk("rstw_rd", rd, 64'd0);
      @(negedge clk); rst = 1'b0;
      tick();
      amo_run("post_rst", 5'b01100, 1'b0, 64'h60, 64'h0FF0, 64'h3C3C, 64'h0C30, 64'h3C3C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/riscv_amo_ctrl.md
Name: riscv_amo_ctrl

Overview:
- Sequences RV64A AMO instructions (AMOSWAP/ADD/XOR/AND/OR/MIN/MAX/MINU/MAXU, .W and .D) as a read-modify-write on the data cache.
- Sits between the LSU and the dcache port and drives that port during an AMO.
- Stalls the pipeline while busy and returns the old memory value for rd.
- Clears the LR/SC reservation whenever an AMO store commits.

Parameters:
XLEN, 64, data/address width
AMO_ADDR_ALIGN_CHK, 1, when 1 a misaligned address aborts the start and raises o_riscv_amo_misaligned

Ports:
i_riscv_lsu_clk  in  1  clock
i_riscv_lsu_rst  in  1  reset, asynchronous, active-high
i_riscv_amo_start  in  1  AMO request from LSU (decoded AMO, memory stage)
i_riscv_amo_funct5  in  5  AMO opcode, encodings in riscv_amo_pkg
i_riscv_amo_word  in  1  1 = .W, 0 = .D
i_riscv_amo_addr  in  XLEN  rs1 address
i_riscv_amo_rs2  in  XLEN  rs2 operand
i_riscv_amo_goto_trap  in  1  CSR trap request
i_riscv_amo_return_trap  in  2  CSR xRET
i_riscv_amo_dcache_stall  in  1  dcache busy/miss; the current request is held
i_riscv_amo_dcache_rdata  in  XLEN  dcache read data, right-justified
o_riscv_amo_dcache_rden  out  1  dcache read enable
o_riscv_amo_dcache_wren  out  1  dcache write enable
o_riscv_amo_dcache_addr  out  XLEN  dcache address
o_riscv_amo_dcache_wdata  out  XLEN  dcache write data
o_riscv_amo_dcache_word  out  1  access size to dcache
o_riscv_amo_busy  out  1  pipeline stall request
o_riscv_amo_done  out  1  one-cycle completion pulse
o_riscv_amo_rd_value  out  XLEN  old memory value, sign-extended for .W
o_riscv_amo_clr_reserv  out  1  one-cycle pulse: invalidate LR reservation
o_riscv_amo_misaligned  out  1  one-cycle pulse: misaligned AMO

Behaviour:
- Reset (async): state IDLE; all outputs 0; internal registers (addr, rs2, op, word, old value, result) 0.
- FSM states: IDLE, READ, CALC, WRITE, DONE.
- IDLE, start accept: accepted when i_riscv_amo_start=1, goto_trap=0, return_trap=0 and the address is aligned (addr[1:0]==0 for .W, addr[2:0]==0 for .D).
  - On accept, latch addr, rs2, funct5 and word; go to READ.
- IDLE, misaligned: if the address is misaligned and AMO_ADDR_ALIGN_CHK=1, pulse o_riscv_amo_misaligned, issue no dcache access, stay in IDLE.
- READ: rden=1, addr=latched addr, word=latched word.
  - Held while dcache_stall=1.
  - First cycle with stall=0: capture rdata into old; go to CALC.
  - For .W, old = sign-extend(rdata[31:0]).
  - If goto_trap=1 in READ: go to IDLE, no write, no done.
- CALC (1 cycle): result = f(old, rs2).
  - ADD wraps modulo 2^32 (.W) or 2^64.
  - MIN/MAX compare signed; MINU/MAXU compare unsigned. For .W, compare on the low 32 bits only.
  - SWAP gives rs2. AND, OR and XOR are bitwise.
  - Undefined funct5: result = old, i.e. the write returns the same value.
- WRITE: wren=1, wdata=result (low 32 bits meaningful for .W).
  - Held while stall=1.
  - On stall=0: pulse clr_reserv; go to DONE.
  - Traps are ignored once in WRITE; the store always completes.
- DONE (1 cycle): done=1, rd_value=old; go to IDLE.
- Busy: o_riscv_amo_busy=1 in READ, CALC and WRITE, and combinationally in IDLE during the accept cycle. It is 0 in DONE so the pipeline advances exactly then.
- Latency with no stalls: accept at cycle 0, READ cycle 1, CALC cycle 2, WRITE cycle 3, DONE cycle 4. Each stall cycle adds 1.
- rden and wren are never both 1. Outside READ/WRITE, address and wdata are 0.
- start=1 while not in IDLE is ignored.
- rd_value holds until the next accept.

Decomposition:
- riscv_amo_pkg: funct5 localparams (SWAP=00001, ADD=00000, XOR=00100, AND=01100, OR=01000, MIN=10000, MAX=10100, MINU=11000, MAXU=11100) and state encodings.
- One combinational sub-module, riscv_amo_alu (old, rs2, funct5, word -> result), holds the arithmetic.

Test Plan:
- AMOADD.D: mem[0x80]=5, rs2=7, no stall -> rden cycle 1, wren cycle 3 with wdata=12, done cycle 4 with rd_value=5, clr_reserv pulse cycle 3.
- AMOMAX.W vs AMOMAXU.W: mem=0xFFFFFFFF, rs2=1 -> signed wdata=1, rd_value=0xFFFF_FFFF_FFFF_FFFF; unsigned wdata=0xFFFFFFFF.
- dcache_stall=1 for 3 cycles in READ and 2 cycles in WRITE -> done at cycle 9, rden/wren held constant while stalled.
- goto_trap=1 during READ -> return to IDLE, no wren, no done, no clr_reserv.
- AMOSWAP.D at 0x84 -> misaligned pulse, no dcache enable, busy stays 0.
- Async reset asserted in WRITE -> all outputs 0 immediately; next start processes normally.
